matrix_op_dispatcher: RTL and testbench
=======================================

# matrix_op_dispatcher

Parametrised operation dispatcher for the matrix-calculator COMPUTE mode. It collects an opcode, operand slot IDs and an optional scalar from the UART decoder stream or the switch/button path. It looks up and checks operand dimensions, computes result dimensions, launches the ALU and supervises it with a timeout. Results and errors go to the UART printer through a held request/acknowledge handshake; errors are also reported as a coded status.

## Interface
Parameters:
- NUM_SLOTS, 12: matrix storage slots; user IDs are 1..NUM_SLOTS.
- DIM_W, 4: width of one dimension field; dimension 0 means the slot is empty.
- DATA_W, 32: decoder word and scalar width.
- NUM_OPS, 5: accepted opcodes 0..NUM_OPS-1, with NUM_OPS ≤ 5.
  - 0 transpose, 1 add, 2 scalar multiply, 3 matrix multiply, 4 Hadamard.
- TIMEOUT_CYC, 1024: maximum number of WAIT cycles before an ALU timeout.
- Derived: ID_W = clog2(NUM_SLOTS), TW = clog2(TIMEOUT_CYC+1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- active  in  1  top FSM is in COMPUTE; low forces a synchronous abort.
- dec_valid  in  1  one-cycle strobe; the decoder word is valid.
- dec_data  in  DATA_W  decoder word, unsigned except when taken as the scalar.
- sw_op  in  3  switch opcode.
- btn_confirm  in  1  one-cycle debounced pulse; accepts sw_op in OP state only.
- id_a, id_b  out  ID_W  zero-based operand slots, driven to storage.
- dim_a_m, dim_a_n, dim_b_m, dim_b_n  in  DIM_W  storage dimensions; valid one cycle after id change.
- alu_start  out  1  one-cycle launch pulse.
- alu_op  out  3  latched opcode.
- scalar_val  out  DATA_W signed  latched scalar.
- alu_done  in  1  ALU completion pulse.
- res_m, res_n  out  DIM_W  result dimensions.
- print_req  out  1  held high until print_ack.
- print_mode  out  4  3 = RESULT, 6 = ERROR.
- print_ack  in  1  printer accepted the request.
- err_code  out  3  last error: 0 none, 1 bad op, 2 bad id, 3 empty slot, 4 dim mismatch, 5 timeout.
- busy  out  1  high in every state except IDLE and OP.

## Operation
- States: IDLE, OP, ID_A, ID_B, SCALAR, LOOKUP, CHECK, START, WAIT, REPORT.
- IDLE → OP unconditionally, one cycle, while active is high.
- OP: accepts dec_valid (dec_data) or btn_confirm (sw_op). If both arrive in the same cycle, dec_valid wins.
  - Value < NUM_OPS: latch alu_op, clear err_code, go to ID_A.
  - Otherwise: error 1.
- ID_A on dec_valid:
  - 1 ≤ value ≤ NUM_SLOTS: id_a = value−1.
  - Next state: ops 0/2 → SCALAR for op 2, LOOKUP for op 0; ops 1/3/4 → ID_B.
  - Out of range: error 2.
- ID_B on dec_valid: same range rule, id_b = value−1, then LOOKUP.
- SCALAR on dec_valid: scalar_val = dec_data (full word, signed), then LOOKUP.
- LOOKUP: one wait cycle for the storage read, then CHECK.
- CHECK, applied in this order:
  - A empty (dim_a_m or dim_a_n == 0) → error 3.
  - Binary op and B empty → error 3.
  - Add/Hadamard: A and B dimensions not equal → error 4.
  - Matrix multiply: dim_a_n ≠ dim_b_m → error 4.
  - Pass → START, latching res_m/res_n:
    - transpose (a_n, a_m);
    - add/scalar/Hadamard (a_m, a_n);
    - multiply (a_m, b_n).
- START: alu_start = 1 for one cycle, timer cleared, then WAIT.
- WAIT:
  - alu_done → REPORT with print_mode 3.
  - Timer reaches TIMEOUT_CYC → error 5.
  - alu_done in the same cycle as the timeout counts as done.
- Error action: set err_code, print_mode = 6, go to REPORT.
- REPORT: print_req held high; on print_ack, drop print_req and go to IDLE.
- dec_valid or btn_confirm outside its accepting state is ignored. alu_done outside WAIT is ignored.
- active low in any state: next cycle go to IDLE.
  - print_req, alu_start and timer are cleared.
  - err_code, ids, res_m/res_n, alu_op and scalar_val are held.

## Timing
- Reset values: all outputs 0, state IDLE.
- Minimum latency from the final operand strobe to alu_start is 3 cycles (LOOKUP, CHECK, START).
- alu_start is never high for more than one cycle and never high twice per command.
- print_req rises the cycle after entry to REPORT.
  - It stays high for any number of cycles until print_ack.
  - It falls the cycle after print_ack is sampled.
- print_ack in the same cycle print_req rises is accepted.
- The timer increments once per WAIT cycle, so a timeout fires after exactly TIMEOUT_CYC WAIT cycles.

## Test plan
- Multiply: op 3, A = slot 2 (2×3), B = slot 5 (3×4). Expect alu_start 3 cycles after the B strobe, res = 2×4, alu_done then print_req with mode 3, print_ack then IDLE, err_code 0.
- Add dimension mismatch: op 1, A 2×3, B 3×2. Expect no alu_start, err_code 4, print_mode 6; print_req holds 10 cycles until ack.
- Range and opcode errors: op 7 → err 1. Op 0 with id 13 → err 2. Id 0 → err 2. Button path sw_op = 2 accepted, dec_valid together with btn_confirm takes dec_data.
- Scalar: op 2, id 1 (3×3), scalar 0xFFFFFFFB. Expect scalar_val = −5, res = 3×3. Transpose of a 2×5 slot gives res = 5×2. An empty slot (dims 0) gives err 3.
- Timeout: ALU never answers. Expect err 5 after exactly TIMEOUT_CYC WAIT cycles. alu_done arriving on that same cycle gives RESULT instead.
- Abort and reset: active low during WAIT → IDLE next cycle, print_req 0. rst asserted during REPORT → all outputs 0 immediately.

Source files
------------

// File: rtl/matrix_op_dispatcher.sv
// Operation dispatcher for COMPUTE mode: collects opcode/operands, validates slot
// dimensions, launches and supervises the ALU, and reports results or errors to the printer.
module matrix_op_dispatcher #(
    parameter  int NUM_SLOTS   = 12,
    parameter  int DIM_W       = 4,
    parameter  int DATA_W      = 32,
    parameter  int NUM_OPS     = 5,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int ID_W        = $clog2(NUM_SLOTS),
    localparam int TW          = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     active,
    input  logic                     dec_valid,
    input  logic [DATA_W-1:0]        dec_data,
    input  logic [2:0]               sw_op,
    input  logic                     btn_confirm,
    output logic [ID_W-1:0]          id_a,
    output logic [ID_W-1:0]          id_b,
    input  logic [DIM_W-1:0]         dim_a_m,
    input  logic [DIM_W-1:0]         dim_a_n,
    input  logic [DIM_W-1:0]         dim_b_m,
    input  logic [DIM_W-1:0]         dim_b_n,
    output logic                     alu_start,
    output logic [2:0]               alu_op,
    output logic signed [DATA_W-1:0] scalar_val,
    input  logic                     alu_done,
    output logic [DIM_W-1:0]         res_m,
    output logic [DIM_W-1:0]         res_n,
    output logic                     print_req,
    output logic [3:0]               print_mode,
    input  logic                     print_ack,
    output logic [2:0]               err_code,
    output logic                     busy
);

    localparam logic [2:0] OP_TRANSPOSE = 3'd0;
    localparam logic [2:0] OP_ADD       = 3'd1;
    localparam logic [2:0] OP_SCALAR    = 3'd2;
    localparam logic [2:0] OP_MATMUL    = 3'd3;
    localparam logic [2:0] OP_HADAMARD  = 3'd4;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BAD_OP   = 3'd1;
    localparam logic [2:0] ERR_BAD_ID   = 3'd2;
    localparam logic [2:0] ERR_EMPTY    = 3'd3;
    localparam logic [2:0] ERR_DIM      = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd5;

    localparam logic [3:0] MODE_RESULT  = 4'd3;
    localparam logic [3:0] MODE_ERROR   = 4'd6;

    typedef enum logic [3:0] {
        S_IDLE, S_OP, S_ID_A, S_ID_B, S_SCALAR,
        S_LOOKUP, S_CHECK, S_START, S_WAIT, S_REPORT
    } state_t;

    state_t                     state_q, state_d;
    logic [ID_W-1:0]            id_a_q, id_a_d, id_b_q, id_b_d;
    logic                       alu_start_q, alu_start_d;
    logic [2:0]                 alu_op_q, alu_op_d;
    logic signed [DATA_W-1:0]   scalar_q, scalar_d;
    logic [DIM_W-1:0]           res_m_q, res_m_d, res_n_q, res_n_d;
    logic                       print_req_q, print_req_d;
    logic [3:0]                 print_mode_q, print_mode_d;
    logic [2:0]                 err_code_q, err_code_d;
    logic [TW-1:0]              timer_q, timer_d;

    logic                       op_strobe;
    logic [DATA_W-1:0]          op_word;
    logic                       id_in_range;
    logic                       is_binary;
    logic                       a_empty, b_empty;
    logic [TW-1:0]              timer_inc;
    logic                       raise_err;
    logic [2:0]                 err_sel;

    // The decoder word takes priority over the switch opcode when both strobe together.
    always_comb begin
        op_strobe   = dec_valid | btn_confirm;
        op_word     = dec_valid ? dec_data : DATA_W'(sw_op);
        id_in_range = (dec_data >= DATA_W'(1)) && (dec_data <= DATA_W'(NUM_SLOTS));
        is_binary   = (alu_op_q == OP_ADD) || (alu_op_q == OP_MATMUL) || (alu_op_q == OP_HADAMARD);
        a_empty     = (dim_a_m == '0) || (dim_a_n == '0);
        b_empty     = (dim_b_m == '0) || (dim_b_n == '0);
        timer_inc   = timer_q + TW'(1);
    end

    always_comb begin
        state_d      = state_q;
        id_a_d       = id_a_q;
        id_b_d       = id_b_q;
        alu_op_d     = alu_op_q;
        scalar_d     = scalar_q;
        res_m_d      = res_m_q;
        res_n_d      = res_n_q;
        print_mode_d = print_mode_q;
        err_code_d   = err_code_q;
        timer_d      = timer_q;
        print_req_d  = 1'b0;
        raise_err    = 1'b0;
        err_sel      = ERR_NONE;

        // Abort drops any command in flight but keeps the last latched results visible.
        if (!active) begin
            state_d = S_IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_OP;
                S_OP: begin
                    if (op_strobe) begin
                        if (op_word < DATA_W'(NUM_OPS)) begin
                            alu_op_d   = op_word[2:0];
                            err_code_d = ERR_NONE;
                            state_d    = S_ID_A;
                        end else begin
                            raise_err = 1'b1;
                            err_sel   = ERR_BAD_OP;
                        end
                    end
                end
                S_ID_A: begin
                    if (dec_valid) begin
                        if (id_in_range) begin
                            id_a_d = ID_W'(dec_data - DATA_W'(1));
                            if (alu_op_q == OP_SCALAR)         state_d = S_SCALAR;
                            else if (alu_op_q == OP_TRANSPOSE) state_d = S_LOOKUP;
                            else                               state_d = S_ID_B;
                        end else begin
                            raise_err = 1'b1;
                            err_sel   = ERR_BAD_ID;
                        end
                    end
                end
                S_ID_B: begin
                    if (dec_valid) begin
                        if (id_in_range) begin
                            id_b_d  = ID_W'(dec_data - DATA_W'(1));
                            state_d = S_LOOKUP;
                        end else begin
                            raise_err = 1'b1;
                            err_sel   = ERR_BAD_ID;
                        end
                    end
                end
                S_SCALAR: begin
                    if (dec_valid) begin
                        scalar_d = dec_data;
                        state_d  = S_LOOKUP;
                    end
                end
                S_LOOKUP: state_d = S_CHECK;
                S_CHECK: begin
                    if (a_empty || (is_binary && b_empty)) begin
                        raise_err = 1'b1;
                        err_sel   = ERR_EMPTY;
                    end else if (((alu_op_q == OP_ADD) || (alu_op_q == OP_HADAMARD)) &&
                                 ((dim_a_m != dim_b_m) || (dim_a_n != dim_b_n))) begin
                        raise_err = 1'b1;
                        err_sel   = ERR_DIM;
                    end else if ((alu_op_q == OP_MATMUL) && (dim_a_n != dim_b_m)) begin
                        raise_err = 1'b1;
                        err_sel   = ERR_DIM;
                    end else begin
                        state_d = S_START;
                        case (alu_op_q)
                            OP_TRANSPOSE: begin res_m_d = dim_a_n; res_n_d = dim_a_m; end
                            OP_MATMUL:    begin res_m_d = dim_a_m; res_n_d = dim_b_n; end
                            default:      begin res_m_d = dim_a_m; res_n_d = dim_a_n; end
                        endcase
                    end
                end
                S_START: begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
                // A completion arriving on the final timeout cycle still wins.
                S_WAIT: begin
                    if (alu_done) begin
                        print_mode_d = MODE_RESULT;
                        state_d      = S_REPORT;
                    end else if (timer_inc == TW'(TIMEOUT_CYC)) begin
                        raise_err = 1'b1;
                        err_sel   = ERR_TIMEOUT;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                S_REPORT: begin
                    if (print_req_q && print_ack) state_d = S_IDLE;
                    else                          print_req_d = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase

            if (raise_err) begin
                err_code_d   = err_sel;
                print_mode_d = MODE_ERROR;
                state_d      = S_REPORT;
            end
        end

        alu_start_d = (state_d == S_START);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            id_a_q       <= '0;
            id_b_q       <= '0;
            alu_start_q  <= 1'b0;
            alu_op_q     <= '0;
            scalar_q     <= '0;
            res_m_q      <= '0;
            res_n_q      <= '0;
            print_req_q  <= 1'b0;
            print_mode_q <= '0;
            err_code_q   <= '0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            id_a_q       <= id_a_d;
            id_b_q       <= id_b_d;
            alu_start_q  <= alu_start_d;
            alu_op_q     <= alu_op_d;
            scalar_q     <= scalar_d;
            res_m_q      <= res_m_d;
            res_n_q      <= res_n_d;
            print_req_q  <= print_req_d;
            print_mode_q <= print_mode_d;
            err_code_q   <= err_code_d;
            timer_q      <= timer_d;
        end
    end

    assign id_a       = id_a_q;
    assign id_b       = id_b_q;
    assign alu_start  = alu_start_q;
    assign alu_op     = alu_op_q;
    assign scalar_val = scalar_q;
    assign res_m      = res_m_q;
    assign res_n      = res_n_q;
    assign print_req  = print_req_q;
    assign print_mode = print_mode_q;
    assign err_code   = err_code_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_OP);

endmodule

// File: tb/tb_matrix_op_dispatcher.sv
// Bench for matrix_op_dispatcher: directed commands, a command-level model of the
// expected outcome, and a per-cycle compare process on the launch/report outputs.
module tb_matrix_op_dispatcher;

    localparam int NUM_SLOTS = 12;
    localparam int DIM_W     = 4;
    localparam int DATA_W    = 32;
    localparam int NUM_OPS   = 5;
    localparam int TIMEOUT   = 20;
    localparam int ID_W      = $clog2(NUM_SLOTS);

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     active;
    logic                     dec_valid;
    logic [DATA_W-1:0]        dec_data;
    logic [2:0]               sw_op;
    logic                     btn_confirm;
    logic [ID_W-1:0]          id_a, id_b;
    logic [DIM_W-1:0]         dim_a_m, dim_a_n, dim_b_m, dim_b_n;
    logic                     alu_start;
    logic [2:0]               alu_op;
    logic signed [DATA_W-1:0] scalar_val;
    logic                     alu_done;
    logic [DIM_W-1:0]         res_m, res_n;
    logic                     print_req;
    logic [3:0]               print_mode;
    logic                     print_ack;
    logic [2:0]               err_code;
    logic                     busy;

    matrix_op_dispatcher #(
        .NUM_SLOTS(NUM_SLOTS), .DIM_W(DIM_W), .DATA_W(DATA_W),
        .NUM_OPS(NUM_OPS), .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .active(active),
        .dec_valid(dec_valid), .dec_data(dec_data),
        .sw_op(sw_op), .btn_confirm(btn_confirm),
        .id_a(id_a), .id_b(id_b),
        .dim_a_m(dim_a_m), .dim_a_n(dim_a_n), .dim_b_m(dim_b_m), .dim_b_n(dim_b_n),
        .alu_start(alu_start), .alu_op(alu_op), .scalar_val(scalar_val),
        .alu_done(alu_done), .res_m(res_m), .res_n(res_n),
        .print_req(print_req), .print_mode(print_mode), .print_ack(print_ack),
        .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    // Storage model: registered read, dimensions valid one cycle after the id changes.
    int slot_m[16];
    int slot_n[16];
    always @(posedge clk) begin
        dim_a_m <= DIM_W'(slot_m[id_a]);
        dim_a_n <= DIM_W'(slot_n[id_a]);
        dim_b_m <= DIM_W'(slot_m[id_b]);
        dim_b_n <= DIM_W'(slot_n[id_b]);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    int         exp_start_cyc = -1;
    int         exp_req_cyc   = -1;
    logic [3:0] exp_mode      = 4'd0;
    logic [2:0] exp_err       = 3'd0;
    logic [2:0] exp_op        = 3'd0;
    int         exp_rm        = 0;
    int         exp_rn        = 0;
    bit         checking      = 1'b0;
    bit         req_prev      = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the expectations set for the current command.
    always @(negedge clk) begin
        if (checking && !rst) begin
            checkOutput("alu_start", 32'(alu_start), (cyc == exp_start_cyc) ? 32'd1 : 32'd0);
            if (print_req && !req_prev)
                checkOutput("req_rise_cycle", cyc, exp_req_cyc);
            if (print_req) begin
                checkOutput("print_mode", 32'(print_mode), 32'(exp_mode));
                checkOutput("err_code", 32'(err_code), 32'(exp_err));
                if (exp_mode == 4'd3) begin
                    checkOutput("res_m", 32'(res_m), exp_rm);
                    checkOutput("res_n", 32'(res_n), exp_rn);
                    checkOutput("alu_op", 32'(alu_op), 32'(exp_op));
                end
            end
        end
        req_prev = print_req;
    end

    task automatic strobe(input logic [31:0] val, output int k);
        @(negedge clk);
        dec_valid = 1'b1;
        dec_data  = val;
        k = cyc;
        @(negedge clk);
        dec_valid = 1'b0;
        dec_data  = '0;
    endtask

    // src: 0 decoder only, 1 button only, 2 both in the same cycle.
    task automatic opStrobe(input int src, input logic [31:0] op_w, input logic [2:0] sw, output int k);
        @(negedge clk);
        if (src != 1) begin dec_valid = 1'b1; dec_data = op_w; end
        if (src != 0) begin btn_confirm = 1'b1; sw_op = sw; end
        k = cyc;
        @(negedge clk);
        dec_valid   = 1'b0;
        dec_data    = '0;
        btn_confirm = 1'b0;
    endtask

    // Issues one command and derives its expected outcome from the dispatcher rules.
    task automatic sendCommand(input int src, input logic [31:0] op_w, input logic [2:0] sw,
                               input logic [31:0] ida, input logic [31:0] idb,
                               input logic [31:0] scal, output bit launched);
        int k, am, an, bm, bn;
        bit at_check, bin;
        logic [31:0] op_v;
        logic [2:0] err;
        exp_start_cyc = -1;
        exp_req_cyc   = -1;
        err = 3'd0;
        at_check = 1'b0;
        op_v = (src == 1) ? 32'(sw) : op_w;
        bin = (op_v == 1) || (op_v == 3) || (op_v == 4);
        repeat (2) @(negedge clk);
        opStrobe(src, op_w, sw, k);
        if (op_v >= NUM_OPS) err = 3'd1;
        else begin
            strobe(ida, k);
            if (ida < 1 || ida > NUM_SLOTS) err = 3'd2;
            else begin
                if (op_v == 2) strobe(scal, k);
                if (bin) begin
                    strobe(idb, k);
                    if (idb < 1 || idb > NUM_SLOTS) err = 3'd2;
                end
                if (err == 3'd0) begin
                    at_check = 1'b1;
                    am = slot_m[int'(ida) - 1];
                    an = slot_n[int'(ida) - 1];
                    bm = bin ? slot_m[int'(idb) - 1] : 0;
                    bn = bin ? slot_n[int'(idb) - 1] : 0;
                    if (am == 0 || an == 0) err = 3'd3;
                    else if (bin && (bm == 0 || bn == 0)) err = 3'd3;
                    else if ((op_v == 1 || op_v == 4) && (am != bm || an != bn)) err = 3'd4;
                    else if (op_v == 3 && an != bm) err = 3'd4;
                    else if (op_v == 0) begin exp_rm = an; exp_rn = am; end
                    else if (op_v == 3) begin exp_rm = am; exp_rn = bn; end
                    else begin exp_rm = am; exp_rn = an; end
                end
            end
        end
        exp_err = err;
        exp_op  = op_v[2:0];
        if (err != 3'd0) begin
            exp_mode    = 4'd6;
            exp_req_cyc = at_check ? k + 4 : k + 2;
            launched    = 1'b0;
        end else begin
            exp_mode      = 4'd3;
            exp_start_cyc = k + 3;
            launched      = 1'b1;
        end
    endtask

    task automatic waitReport(input int hold);
        int n = 0;
        while (!print_req && n < TIMEOUT + 40) begin @(negedge clk); n++; end
        if (!print_req) begin
            checkOutput("print_req_seen", 32'(print_req), 32'd1);
            return;
        end
        repeat (hold) begin
            @(negedge clk);
            checkOutput("req_hold", 32'(print_req), 32'd1);
        end
        print_ack = 1'b1;
        @(negedge clk);
        print_ack = 1'b0;
        checkOutput("req_drop", 32'(print_req), 32'd0);
        checkOutput("busy_after_ack", 32'(busy), 32'd0);
        checkOutput("err_code_after", 32'(err_code), 32'(exp_err));
    endtask

    // done_delay: WAIT cycle on which alu_done pulses (1..TIMEOUT), 0 for never.
    task automatic applyStimulus(input int src, input logic [31:0] op_w, input logic [2:0] sw,
                                 input logic [31:0] ida, input logic [31:0] idb,
                                 input logic [31:0] scal, input int done_delay, input int hold);
        bit launched;
        int s, n;
        sendCommand(src, op_w, sw, ida, idb, scal, launched);
        if (launched) begin
            s = exp_start_cyc;
            n = 0;
            while (cyc < s && n < 20) begin @(negedge clk); n++; end
            if (done_delay > 0 && done_delay <= TIMEOUT) begin
                exp_req_cyc = s + done_delay + 2;
                repeat (done_delay) @(negedge clk);
                alu_done = 1'b1;
                @(negedge clk);
                alu_done = 1'b0;
            end else begin
                exp_err     = 3'd5;
                exp_mode    = 4'd6;
                exp_req_cyc = s + TIMEOUT + 2;
            end
        end
        waitReport(hold);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_alu_start"}, 32'(alu_start), 32'd0);
        checkOutput({tag, "_alu_op"}, 32'(alu_op), 32'd0);
        checkOutput({tag, "_scalar"}, 32'(scalar_val), 32'd0);
        checkOutput({tag, "_res_m"}, 32'(res_m), 32'd0);
        checkOutput({tag, "_res_n"}, 32'(res_n), 32'd0);
        checkOutput({tag, "_print_req"}, 32'(print_req), 32'd0);
        checkOutput({tag, "_print_mode"}, 32'(print_mode), 32'd0);
        checkOutput({tag, "_err_code"}, 32'(err_code), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_id_a"}, 32'(id_a), 32'd0);
        checkOutput({tag, "_id_b"}, 32'(id_b), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no summary, expected run to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit launched;
        int s, n;
        rst = 1'b1; active = 1'b1; dec_valid = 1'b0; dec_data = '0;
        sw_op = 3'd0; btn_confirm = 1'b0; alu_done = 1'b0; print_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin slot_m[i] = 1; slot_n[i] = 1; end
        slot_m[0] = 3; slot_n[0] = 3;
        slot_m[1] = 2; slot_n[1] = 3;
        slot_m[2] = 3; slot_n[2] = 2;
        slot_m[3] = 0; slot_n[3] = 0;
        slot_m[4] = 3; slot_n[4] = 4;
        slot_m[5] = 2; slot_n[5] = 5;
        slot_m[6] = 2; slot_n[6] = 3;
        slot_m[7] = 3; slot_n[7] = 0;
        slot_m[8] = 4; slot_n[8] = 4;
        slot_m[10] = 2; slot_n[10] = 2;
        slot_m[11] = 5; slot_n[11] = 5;

        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        checking = 1'b1;

        // Matrix multiply 2x3 * 3x4.
        applyStimulus(0, 32'd3, 3'd0, 32'd2, 32'd5, 32'd0, 4, 0);
        checkOutput("mul_res_m_lit", 32'(res_m), 32'd2);
        checkOutput("mul_res_n_lit", 32'(res_n), 32'd4);
        checkOutput("mul_err_lit", 32'(err_code), 32'd0);

        // Add with 2x3 vs 3x2, request held for 10 cycles.
        applyStimulus(0, 32'd1, 3'd0, 32'd2, 32'd3, 32'd0, 1, 10);
        checkOutput("add_err_lit", 32'(err_code), 32'd4);
        checkOutput("add_mode_lit", 32'(print_mode), 32'd6);

        // Opcode and id range errors.
        applyStimulus(0, 32'd7, 3'd0, 32'd1, 32'd1, 32'd0, 1, 0);
        checkOutput("op7_err_lit", 32'(err_code), 32'd1);
        applyStimulus(0, 32'd5, 3'd0, 32'd1, 32'd1, 32'd0, 1, 0);
        applyStimulus(0, 32'd0, 3'd0, 32'd13, 32'd1, 32'd0, 1, 0);
        checkOutput("id13_err_lit", 32'(err_code), 32'd2);
        applyStimulus(0, 32'd0, 3'd0, 32'd0, 32'd1, 32'd0, 1, 0);
        applyStimulus(0, 32'd1, 3'd0, 32'd1, 32'd13, 32'd0, 1, 0);
        applyStimulus(0, 32'd0, 3'd0, 32'd12, 32'd1, 32'd0, 2, 0);
        applyStimulus(1, 32'd0, 3'd6, 32'd1, 32'd1, 32'd0, 1, 0);

        // Button-path scalar multiply with a negative scalar.
        applyStimulus(1, 32'd0, 3'd2, 32'd1, 32'd1, 32'hFFFF_FFFB, 3, 0);
        checkOutput("scalar_lit", 32'(scalar_val), 32'hFFFF_FFFB);
        checkOutput("scalar_res_lit", 32'(res_m), 32'd3);

        // Simultaneous strobes: decoder transpose beats switch multiply.
        applyStimulus(2, 32'd0, 3'd3, 32'd6, 32'd1, 32'd0, 1, 0);
        checkOutput("tr_alu_op_lit", 32'(alu_op), 32'd0);
        checkOutput("tr_res_m_lit", 32'(res_m), 32'd5);
        checkOutput("tr_res_n_lit", 32'(res_n), 32'd2);

        // Empty-slot and dimension checks, including check order.
        applyStimulus(0, 32'd0, 3'd0, 32'd4, 32'd1, 32'd0, 1, 0);
        checkOutput("empty_err_lit", 32'(err_code), 32'd3);
        applyStimulus(0, 32'd0, 3'd0, 32'd8, 32'd1, 32'd0, 1, 0);
        applyStimulus(0, 32'd4, 3'd0, 32'd1, 32'd8, 32'd0, 1, 0);
        applyStimulus(0, 32'd1, 3'd0, 32'd4, 32'd2, 32'd0, 1, 0);
        applyStimulus(0, 32'd3, 3'd0, 32'd2, 32'd2, 32'd0, 1, 0);
        applyStimulus(0, 32'd4, 3'd0, 32'd2, 32'd7, 32'd0, 2, 3);
        applyStimulus(0, 32'd3, 3'd0, 32'd3, 32'd2, 32'd0, 5, 0);

        // Timeout, then completion on the very last WAIT cycle.
        applyStimulus(0, 32'd0, 3'd0, 32'd9, 32'd1, 32'd0, 0, 0);
        checkOutput("timeout_err_lit", 32'(err_code), 32'd5);
        applyStimulus(0, 32'd0, 3'd0, 32'd9, 32'd1, 32'd0, TIMEOUT, 0);
        checkOutput("late_done_mode_lit", 32'(print_mode), 32'd3);

        // Abort while waiting on the ALU; stray alu_done afterwards is ignored.
        sendCommand(0, 32'd0, 3'd0, 32'd3, 32'd1, 32'd0, launched);
        s = exp_start_cyc;
        n = 0;
        while (cyc < s + 2 && n < 20) begin @(negedge clk); n++; end
        active = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_req", 32'(print_req), 32'd0);
        @(negedge clk);
        active = 1'b1;
        alu_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        alu_done = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("abort_req_later", 32'(print_req), 32'd0);
        checkOutput("abort_res_m_held", 32'(res_m), 32'd2);
        checkOutput("abort_res_n_held", 32'(res_n), 32'd3);
        checkOutput("abort_err_held", 32'(err_code), 32'd0);
        applyStimulus(0, 32'd4, 3'd0, 32'd11, 32'd11, 32'd0, 2, 0);

        // Asynchronous reset while a report is pending.
        sendCommand(0, 32'd1, 3'd0, 32'd11, 32'd11, 32'd0, launched);
        s = exp_start_cyc;
        exp_req_cyc = s + 3;
        n = 0;
        while (cyc < s + 1 && n < 20) begin @(negedge clk); n++; end
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
        n = 0;
        while (!print_req && n < 20) begin @(negedge clk); n++; end
        checkOutput("pre_reset_req", 32'(print_req), 32'd1);
        #2 rst = 1'b1;
        exp_start_cyc = -1;
        exp_req_cyc   = -1;
        #1 checkAllZero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 32'd3, 3'd0, 32'd2, 32'd5, 32'd0, 1, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
